// File: rtl/mem_io_loader_if.sv
// Signal bundle between mem_io_loader and its surroundings: input byte stream,
// core memory write/read port, core control, output byte stream and status.
interface mem_io_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;

  logic        memEn;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        memRdEn;
  logic [31:0] memRdAddr;
  logic [7:0]  memRdData;

  logic        coreReset;
  logic [31:0] pc;
  logic [31:0] a0;

  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;

  logic        done;
  logic        timedOut;
  logic [31:0] retCode;

  // master: the loader itself
  modport master (
    input  in_valid, in_data, in_last, memRdData, pc, a0, out_ready,
    output in_ready, memEn, memAddr, memData, memRdEn, memRdAddr, coreReset,
           out_valid, out_data, out_last, done, timedOut, retCode
  );

  // slave: core, memory and stream endpoints around the loader
  modport slave (
    output in_valid, in_data, in_last, memRdData, pc, a0, out_ready,
    input  in_ready, memEn, memAddr, memData, memRdEn, memRdAddr, coreReset,
           out_valid, out_data, out_last, done, timedOut, retCode
  );
endinterface

// File: rtl/mem_io_loader.sv
// Load/run/unload sequencer around the processor core: writes the input stream
// into core memory, releases the core, waits for halt, streams result bytes out.
module mem_io_loader #(
  parameter logic [31:0] DIN_ADDR     = 32'h3E00,
  parameter logic [31:0] DOUT_ADDR    = 32'h3F00,
  parameter int unsigned MAX_IO_SIZE  = 256,
  parameter logic [31:0] HALT_PC      = 32'h14,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 100000
) (
  input logic             clock,
  input logic             reset,
  mem_io_loader_if.master bus
);

  localparam int unsigned IDX_W = $clog2(MAX_IO_SIZE);
  localparam int unsigned NB_W  = IDX_W + 1;
  localparam int unsigned CYC_W = $clog2(TIMEOUT + RESET_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(MAX_IO_SIZE - 1);
  localparam logic [CYC_W-1:0] RST_LAST   = CYC_W'(RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_LAST   = CYC_W'(TIMEOUT - 1);
  localparam logic [31:0]      WORD_CLAMP = 32'(MAX_IO_SIZE / 4);

  typedef enum logic [2:0] {
    LOAD,
    CORE_RST,
    RUN,
    RD,
    SEND,
    DONE,
    TMO
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  k;
  logic [NB_W-1:0]   nbytes;
  logic [CYC_W-1:0]  cyc;
  logic              rd_wait;

  logic              beat;
  logic              k_last;
  logic [NB_W-1:0]   halt_nbytes;

  assign bus.in_ready = (state == LOAD);
  assign beat         = bus.in_valid && (state == LOAD);
  assign k_last       = ({1'b0, k} == (nbytes - NB_W'(1)));

  // Output length in bytes: a0 words, clamped so it never exceeds the output region
  assign halt_nbytes = (bus.a0 >= WORD_CLAMP) ? NB_W'(MAX_IO_SIZE)
                                              : NB_W'(bus.a0 * 32'd4);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= LOAD;
      idx           <= '0;
      k             <= '0;
      nbytes        <= '0;
      cyc           <= '0;
      rd_wait       <= 1'b0;
      bus.memEn     <= 1'b0;
      bus.memAddr   <= '0;
      bus.memData   <= '0;
      bus.memRdEn   <= 1'b0;
      bus.memRdAddr <= '0;
      bus.coreReset <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.done      <= 1'b0;
      bus.timedOut  <= 1'b0;
      bus.retCode   <= '0;
    end else begin
      // Write and read strobes are single-cycle pulses
      bus.memEn   <= 1'b0;
      bus.memRdEn <= 1'b0;

      unique case (state)
        LOAD: begin
          if (beat) begin
            bus.memEn   <= 1'b1;
            bus.memAddr <= DIN_ADDR + 32'(idx);
            bus.memData <= {24'h0, bus.in_data};
            if (bus.in_last || (idx == IDX_LAST)) begin
              state <= CORE_RST;
              cyc   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        CORE_RST: begin
          if (cyc == RST_LAST) begin
            state         <= RUN;
            bus.coreReset <= 1'b0;
            cyc           <= '0;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end

        RUN: begin
          cyc <= cyc + CYC_W'(1);
          // Halt takes priority over a coincident timeout
          if (bus.pc == HALT_PC) begin
            bus.retCode <= bus.a0;
            nbytes      <= halt_nbytes;
            k           <= '0;
            if (halt_nbytes == '0) begin
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.coreReset <= 1'b1;
            end else begin
              state         <= RD;
              rd_wait       <= 1'b0;
              bus.memRdEn   <= 1'b1;
              bus.memRdAddr <= DOUT_ADDR;
            end
          end else if (cyc == TMO_LAST) begin
            state         <= TMO;
            bus.timedOut  <= 1'b1;
            bus.coreReset <= 1'b1;
          end
        end

        RD: begin
          // First cycle issues the read, second captures the returned byte
          if (!rd_wait) begin
            rd_wait <= 1'b1;
          end else begin
            rd_wait       <= 1'b0;
            bus.out_data  <= bus.memRdData;
            bus.out_valid <= 1'b1;
            bus.out_last  <= k_last;
            state         <= SEND;
          end
        end

        SEND: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            if (k_last) begin
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.coreReset <= 1'b1;
            end else begin
              k             <= k + IDX_W'(1);
              state         <= RD;
              bus.memRdEn   <= 1'b1;
              bus.memRdAddr <= DOUT_ADDR + 32'(k + IDX_W'(1));
            end
          end
        end

        DONE: begin
          bus.done      <= 1'b1;
          bus.coreReset <= 1'b1;
        end

        TMO: begin
          bus.timedOut  <= 1'b1;
          bus.coreReset <= 1'b1;
          bus.out_valid <= 1'b0;
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_loader.sv
// Scoreboard bench for mem_io_loader: expected memory writes and output bytes are
// queued by the stimulus and popped by a monitor that samples on the falling edge.
module tb_mem_io_loader;

  localparam logic [31:0] DIN  = 32'h3E00;
  localparam logic [31:0] DOUT = 32'h3F00;
  localparam logic [31:0] HALT = 32'h14;
  localparam int          MAX  = 256;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } out_t;

  logic clock;
  logic reset;
  mem_io_loader_if bus();

  mem_io_loader #(
    .DIN_ADDR(DIN), .DOUT_ADDR(DOUT), .MAX_IO_SIZE(MAX),
    .HALT_PC(HALT), .RESET_CYCLES(2), .TIMEOUT(50)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  wr_t        exp_wr_q[$];
  out_t       exp_out_q[$];
  logic [7:0] out_mem [0:255];
  int         checks;
  int         errors;
  int         n_out;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Core output region: synchronous read, data one cycle after memRdEn
  always @(posedge clock) begin
    if (bus.memRdEn === 1'b1) bus.memRdData <= out_mem[8'(bus.memRdAddr - DOUT)];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic       prev_stall;
    logic [7:0] prev_data;
    wr_t        w;
    out_t       o;
    prev_stall = 1'b0;
    prev_data  = 8'h0;
    forever begin
      @(negedge clock);
      if (bus.memEn === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_wr_extra actual=%h/%h required=none", bus.memAddr, bus.memData);
        end else begin
          w = exp_wr_q.pop_front();
          check("mem_wr_addr", bus.memAddr, w.addr);
          check("mem_wr_data", bus.memData, {24'h0, w.data});
        end
      end
      if (bus.out_valid === 1'b1 && prev_stall)
        check("out_hold", 32'(bus.out_data), 32'(prev_data));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_out++;
        if (exp_out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra actual=%h required=none", bus.out_data);
        end else begin
          o = exp_out_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(o.data));
          check("out_last", 32'(bus.out_last), 32'(o.last));
        end
      end
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      prev_data  = bus.out_data;
    end
  endtask

  task automatic apply_reset();
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.pc        = 32'h0;
    bus.a0        = 32'h0;
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b1;
    exp_out_q.delete();
  endtask

  // Streams n bytes seed, seed+1, ...; only the first MAX may be accepted
  task automatic load(input int n, input logic use_last, input logic [7:0] seed);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d            = 8'(int'(seed) + i);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = use_last && (i == n - 1);
      check("in_ready", 32'(bus.in_ready), 32'(i < MAX));
      if (i < MAX) begin
        check("core_reset_load", 32'(bus.coreReset), 32'd1);
        exp_wr_q.push_back('{DIN + 32'(i), d});
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic release_core();
    check("in_ready_after_load", 32'(bus.in_ready), 32'd0);
    check("core_reset_hold0", 32'(bus.coreReset), 32'd1);
    tick();
    check("core_reset_hold1", 32'(bus.coreReset), 32'd1);
    tick();
    check("core_reset_released", 32'(bus.coreReset), 32'd0);
  endtask

  task automatic halt(input logic [31:0] code);
    bus.a0 = code;
    bus.pc = HALT;
    tick();
    bus.pc = 32'h0;
  endtask

  task automatic expect_out(input int n);
    for (int i = 0; i < n; i++) exp_out_q.push_back('{out_mem[i], (i == n - 1)});
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    while (bus.done !== 1'b1 && t < limit) begin
      tick();
      t++;
    end
    check("done", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int t;
    checks = 0;
    errors = 0;
    n_out  = 0;
    reset  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h0;
    bus.in_last   = 1'b0;
    bus.pc        = 32'h0;
    bus.a0        = 32'h0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) out_mem[i] = 8'(i + 10);
    fork
      monitor();
    join_none

    // Reset state
    apply_reset();
    check("rst_core_reset", 32'(bus.coreReset), 32'd1);
    check("rst_in_ready",   32'(bus.in_ready),  32'd1);
    check("rst_mem_en",     32'(bus.memEn),     32'd0);
    check("rst_mem_rd_en",  32'(bus.memRdEn),   32'd0);
    check("rst_out_valid",  32'(bus.out_valid), 32'd0);
    check("rst_done",       32'(bus.done),      32'd0);
    check("rst_timed_out",  32'(bus.timedOut),  32'd0);
    check("rst_ret_code",   bus.retCode,        32'd0);

    // Load 01..04, release, halt with a0=2, unload 0A..11
    load(4, 1'b1, 8'h01);
    release_core();
    bus.out_ready = 1'b1;
    expect_out(8);
    halt(32'd2);
    wait_done(100);
    check("halt_ret_code",   bus.retCode,            32'd2);
    check("halt_core_reset", 32'(bus.coreReset),     32'd1);
    check("halt_out_valid",  32'(bus.out_valid),     32'd0);
    check("halt_out_left",   32'(exp_out_q.size()),  32'd0);
    check("halt_wr_left",    32'(exp_wr_q.size()),   32'd0);

    // Overflow: 300 bytes without in_last, only 256 written
    apply_reset();
    load(300, 1'b0, 8'h20);
    repeat (3) tick();
    check("ovf_wr_left",  32'(exp_wr_q.size()), 32'd0);
    check("ovf_in_ready", 32'(bus.in_ready),    32'd0);

    // Backpressure on the third output byte
    apply_reset();
    load(1, 1'b1, 8'h55);
    release_core();
    bus.out_ready = 1'b1;
    n_out = 0;
    expect_out(8);
    halt(32'd2);
    t = 0;
    while (n_out < 2 && t < 30) begin
      tick();
      t++;
    end
    check("bp_reach_byte2", 32'(n_out), 32'd2);
    bus.out_ready = 1'b0;
    repeat (10) tick();
    bus.out_ready = 1'b1;
    wait_done(100);
    check("bp_out_left", 32'(exp_out_q.size()), 32'd0);
    check("bp_out_count", 32'(n_out), 32'd8);

    // a0=0: done without any output byte
    apply_reset();
    load(1, 1'b1, 8'h66);
    release_core();
    bus.out_ready = 1'b1;
    halt(32'd0);
    check("zero_done",       32'(bus.done),      32'd1);
    check("zero_core_reset", 32'(bus.coreReset), 32'd1);
    check("zero_out_valid",  32'(bus.out_valid), 32'd0);
    repeat (5) tick();
    check("zero_out_valid_later", 32'(bus.out_valid), 32'd0);

    // Large unsigned a0 clamps to the full 256-byte output region
    apply_reset();
    load(1, 1'b1, 8'h11);
    release_core();
    bus.out_ready = 1'b1;
    expect_out(MAX);
    halt(32'h8000_0001);
    wait_done(1000);
    check("clamp_ret_code", bus.retCode,           32'h8000_0001);
    check("clamp_out_left", 32'(exp_out_q.size()), 32'd0);

    // Timeout 50 run cycles after coreReset falls
    apply_reset();
    load(2, 1'b1, 8'h30);
    release_core();
    repeat (49) tick();
    check("tmo_not_yet",      32'(bus.timedOut),  32'd0);
    check("tmo_core_running", 32'(bus.coreReset), 32'd0);
    tick();
    check("tmo_timed_out",  32'(bus.timedOut),  32'd1);
    check("tmo_core_reset", 32'(bus.coreReset), 32'd1);
    check("tmo_out_valid",  32'(bus.out_valid), 32'd0);
    check("tmo_done",       32'(bus.done),      32'd0);

    // Reset while a byte is waiting in SEND
    apply_reset();
    load(3, 1'b1, 8'h40);
    release_core();
    bus.out_ready = 1'b0;
    halt(32'd1);
    t = 0;
    while (bus.out_valid !== 1'b1 && t < 10) begin
      tick();
      t++;
    end
    check("mid_send_reached", 32'(bus.out_valid), 32'd1);
    reset = 1'b0;
    tick();
    check("mid_out_valid",  32'(bus.out_valid), 32'd0);
    check("mid_core_reset", 32'(bus.coreReset), 32'd1);
    check("mid_in_ready",   32'(bus.in_ready),  32'd1);
    check("mid_done",       32'(bus.done),      32'd0);
    reset = 1'b1;
    exp_out_q.delete();
    load(1, 1'b1, 8'h77);
    release_core();
    check("mid_reload_wr_left", 32'(exp_wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
